// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    JBack = 2'b00,
    JFwd  = 2'b01,
    JAbs  = 2'b10,
    JRet  = 2'b11
  } jmode_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a small LIFO with push, pop and synchronous clear.
module pc_ras #(
  parameter int unsigned PC_BITS   = 12,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [PC_BITS-1:0]             din,
  output logic [PC_BITS-1:0]             top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IdxW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_BITS-1:0] mem_q [RAS_DEPTH];
  logic [CntW-1:0]    count_q;
  logic [CntW-1:0]    top_ptr;

  assign full    = (count_q == CntW'(RAS_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign top_ptr = count_q - CntW'(1);
  assign top     = empty ? '0 : mem_q[top_ptr[IdxW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + CntW'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset; entries are only read below count_q.
  always_ff @(posedge clock) begin
    if (!clear && push && !full) begin
      mem_q[count_q[IdxW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: run/halt FSM, next-pc selection, call/return stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_BITS     = 12,
  parameter int unsigned OFFSET_BITS = 8,
  parameter int unsigned RAS_DEPTH   = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           stall,
  input  logic                           jump_en,
  input  jmode_t                         jump_mode,
  input  logic                           call,
  input  logic                           halt,
  input  logic [OFFSET_BITS-1:0]         target,
  output logic [PC_BITS-1:0]             pc,
  output logic                           running,
  output logic                           done,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_err
);

  state_t                           state_q;
  logic [PC_BITS-1:0]               pc_q;
  logic                             ras_err_q;
  logic [PC_BITS+OFFSET_BITS-1:0]   tgt_wide;
  logic [PC_BITS-1:0]               tgt_ext;
  logic [PC_BITS-1:0]               pc_inc;
  logic [PC_BITS-1:0]               ras_top;
  logic                             ras_full;
  logic                             ras_empty;
  logic                             advance;
  logic                             is_jump;
  logic                             ras_push;
  logic                             ras_pop;

  // Zero-extend (or truncate) the decoder field to pc width.
  assign tgt_wide = {{PC_BITS{1'b0}}, target};
  assign tgt_ext  = tgt_wide[PC_BITS-1:0];
  assign pc_inc   = pc_q + PC_BITS'(1);

  assign advance  = (state_q == StRun) && !start && !halt && !stall;
  assign is_jump  = advance && jump_en;
  assign ras_push = is_jump && call && (jump_mode != JRet);
  assign ras_pop  = is_jump && (jump_mode == JRet) && !ras_empty;

  pc_ras #(
    .PC_BITS  (PC_BITS),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (ras_push),
    .pop    (ras_pop),
    .clear  (start),
    .din    (pc_inc),
    .top    (ras_top),
    .count  (ras_count),
    .full   (ras_full),
    .empty  (ras_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ras_err_q <= 1'b0;
    end else if (start) begin
      state_q   <= StRun;
      pc_q      <= '0;
      ras_err_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (halt) begin
            state_q <= StHalt;
          end else if (!stall) begin
            if (jump_en) begin
              unique case (jump_mode)
                JBack: pc_q <= pc_q - tgt_ext;
                JFwd:  pc_q <= pc_q + tgt_ext;
                JAbs:  pc_q <= tgt_ext;
                JRet: begin
                  // Return with nothing stacked falls through to the next instruction.
                  if (ras_empty) begin
                    pc_q      <= pc_inc;
                    ras_err_q <= 1'b1;
                  end else begin
                    pc_q <= ras_top;
                  end
                end
                default: pc_q <= pc_inc;
              endcase
              if (ras_push && ras_full) begin
                ras_err_q <= 1'b1;
              end
            end else begin
              pc_q <= pc_inc;
            end
          end
        end
        StIdle, StHalt: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == StRun);
  assign done    = (state_q == StHalt);
  assign ras_err = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic vs a reference model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int PcBits   = 12;
  localparam int OffBits  = 8;
  localparam int RasDepth = 4;
  localparam int PcMask   = (1 << PcBits) - 1;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 start, stall, jump_en, call, halt;
  jmode_t               jump_mode;
  logic [OffBits-1:0]   target;
  logic [PcBits-1:0]    pc;
  logic                 running, done, ras_err;
  logic [2:0]           ras_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int     m_pc;
  state_t m_st;
  int     m_stack[$];
  bit     m_err;

  always #5 clock = ~clock;

  pc_sequencer #(
    .PC_BITS    (PcBits),
    .OFFSET_BITS(OffBits),
    .RAS_DEPTH  (RasDepth)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .stall    (stall),
    .jump_en  (jump_en),
    .jump_mode(jump_mode),
    .call     (call),
    .halt     (halt),
    .target   (target),
    .pc       (pc),
    .running  (running),
    .done     (done),
    .ras_count(ras_count),
    .ras_err  (ras_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, int'(pc), m_pc);
    check({tag, ".running"}, int'(running), int'(m_st == StRun));
    check({tag, ".done"}, int'(done), int'(m_st == StHalt));
    check({tag, ".ras_count"}, int'(ras_count), m_stack.size());
    check({tag, ".ras_err"}, int'(ras_err), int'(m_err));
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_st = StIdle;
    m_stack.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_clock(bit st, bit hl, bit sl, bit je, jmode_t md, bit cl, int tg);
    int old_pc = m_pc;
    if (st) begin
      m_pc = 0;
      m_stack.delete();
      m_err = 1'b0;
      m_st = StRun;
    end else if (m_st == StRun) begin
      if (hl) m_st = StHalt;
      else if (!sl) begin
        if (!je) m_pc = (old_pc + 1) & PcMask;
        else begin
          case (md)
            JBack: m_pc = (old_pc - tg) & PcMask;
            JFwd:  m_pc = (old_pc + tg) & PcMask;
            JAbs:  m_pc = tg & PcMask;
            default: begin
              if (m_stack.size() > 0) m_pc = m_stack.pop_back();
              else begin
                m_pc = (old_pc + 1) & PcMask;
                m_err = 1'b1;
              end
            end
          endcase
          if (cl && md != JRet) begin
            if (m_stack.size() < RasDepth) m_stack.push_back((old_pc + 1) & PcMask);
            else m_err = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic step(input string tag, input bit st, input bit hl, input bit sl, input bit je,
                      input jmode_t md, input bit cl, input int tg);
    start = st; halt = hl; stall = sl; jump_en = je; jump_mode = md; call = cl;
    target = OffBits'(tg);
    model_clock(st, hl, sl, je, md, cl, tg);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, JBack, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    {start, stall, jump_en, call, halt} = '0;
    jump_mode = JBack;
    target = '0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_all("idle_hold");

    // T1: start then count up.
    step("t1_start", 1, 0, 0, 0, JBack, 0, 0);
    for (int i = 0; i < 5; i++) idle("t1_inc");
    check("t1_pc5", int'(pc), 5);

    // T2: relative and absolute jumps from pc=10.
    step("t2_abs10", 0, 0, 0, 1, JAbs, 0, 10);
    step("t2_back", 0, 0, 0, 1, JBack, 0, 3);
    check("t2_pc7", int'(pc), 7);
    step("t2_fwd", 0, 0, 0, 1, JFwd, 0, 20);
    check("t2_pc27", int'(pc), 27);
    step("t2_abs", 0, 0, 0, 1, JAbs, 0, 8'hC8);
    check("t2_pc200", int'(pc), 200);

    // T3: wrap-around in both directions.
    step("t3_abs0", 0, 0, 0, 1, JAbs, 0, 0);
    step("t3_back1", 0, 0, 0, 1, JBack, 0, 1);
    check("t3_pc4095", int'(pc), 4095);
    idle("t3_wrap");
    check("t3_pc0", int'(pc), 0);
    step("t3_abs2", 0, 0, 0, 1, JAbs, 0, 2);
    step("t3_back5", 0, 0, 0, 1, JBack, 0, 5);
    check("t3_pc4093", int'(pc), 4093);

    // T4: call and return.
    step("t4_abs30", 0, 0, 0, 1, JAbs, 0, 30);
    step("t4_call", 0, 0, 0, 1, JAbs, 1, 100);
    check("t4_pc100", int'(pc), 100);
    check("t4_cnt1", int'(ras_count), 1);
    idle("t4_body");
    step("t4_ret", 0, 0, 0, 1, JRet, 0, 0);
    check("t4_pc31", int'(pc), 31);
    check("t4_cnt0", int'(ras_count), 0);

    // T5: overflow then underflow.
    for (int i = 0; i < 5; i++) step("t5_call", 0, 0, 0, 1, JFwd, 1, 7);
    check("t5_cnt4", int'(ras_count), 4);
    check("t5_err", int'(ras_err), 1);
    for (int i = 0; i < 4; i++) step("t5_ret", 0, 0, 0, 1, JRet, 0, 0);
    step("t5_ret_empty", 0, 0, 0, 1, JRet, 0, 0);
    check("t5_err_sticky", int'(ras_err), 1);
    step("t5_call_ret_mode", 0, 0, 0, 1, JRet, 1, 0);

    // T6: stall, halt, restart, async reset.
    step("t6_stall", 0, 0, 1, 1, JAbs, 1, 99);
    step("t6_halt", 0, 1, 0, 0, JBack, 0, 0);
    check("t6_done", int'(done), 1);
    step("t6_frozen", 0, 0, 0, 1, JAbs, 0, 55);
    idle("t6_frozen2");
    step("t6_restart", 1, 0, 0, 0, JBack, 0, 0);
    check("t6_err_clr", int'(ras_err), 0);
    for (int i = 0; i < 3; i++) idle("t6_run");
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_async_rst");
    @(posedge clock); #1;
    reset_n = 1'b1;
    step("t6_start2", 1, 0, 0, 0, JBack, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit st = ($urandom_range(0, 49) == 0);
      bit hl = ($urandom_range(0, 39) == 0);
      bit sl = ($urandom_range(0, 5) == 0);
      bit je = ($urandom_range(0, 1) == 0);
      bit cl = ($urandom_range(0, 2) == 0);
      jmode_t md = jmode_t'($urandom_range(0, 3));
      int tg = int'($urandom_range(0, 255));
      if (m_st == StHalt && $urandom_range(0, 3) == 0) st = 1'b1;
      step("rand", st, hl, sl, je, md, cl, tg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
